// File: rtl/scan_cfg_pkg.sv
// Shared definitions for the configuration scan-chain loader: FSM state codes,
// default host word width and the counter-width helper.
package scan_cfg_pkg;

  localparam int SCAN_WORD_W = 8;

  typedef logic [1:0] scan_state_t;

  localparam scan_state_t ST_IDLE      = 2'd0;
  localparam scan_state_t ST_WAIT_WORD = 2'd1;
  localparam scan_state_t ST_SHIFT     = 2'd2;
  localparam scan_state_t ST_DONE      = 2'd3;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/scan_word_serializer.sv
// Word buffer shifted out MSB-first with a per-word bit counter.
// With SCAN_CFG_READBACK_EN defined, also captures the chain tail into rb_data.
module scan_word_serializer
  import scan_cfg_pkg::*;
#(
  parameter int WORD_W = SCAN_WORD_W,
  parameter int CNT_W  = cnt_w(WORD_W)
) (
  input  logic              scan_clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic [CNT_W-1:0]  nbits,
  input  logic              shift,
  input  logic              scan_out,
  output logic              scan_in,
  output logic              last,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  logic [WORD_W-1:0] buffer;
  logic [CNT_W-1:0]  bit_cnt;

  assign scan_in = buffer[WORD_W-1];
  assign last    = shift && (bit_cnt == CNT_W'(1));

  // The buffer is emptied after each word so scan_in idles at 0 between words.
  always_ff @(posedge scan_clk or posedge rst) begin
    if (rst) begin
      buffer  <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      buffer  <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      buffer  <= word;
      bit_cnt <= nbits;
    end else if (shift) begin
      buffer  <= last ? '0 : {buffer[WORD_W-2:0], 1'b0};
      bit_cnt <= bit_cnt - CNT_W'(1);
    end
  end

`ifdef SCAN_CFG_READBACK_EN
  logic [WORD_W-1:0] capture;
  logic [WORD_W-1:0] cap_next;
  logic [CNT_W-1:0]  word_bits;
  logic [CNT_W-1:0]  pad;

  assign cap_next = {capture[WORD_W-2:0], scan_out};
  assign pad      = CNT_W'(WORD_W) - word_bits;

  // A short final word lands in the low bits; shift it up to left-justify.
  always_ff @(posedge scan_clk or posedge rst) begin
    if (rst) begin
      capture   <= '0;
      word_bits <= '0;
      rb_data   <= '0;
      rb_valid  <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (clear) begin
        capture <= '0;
      end else if (load) begin
        word_bits <= nbits;
      end else if (shift) begin
        if (last) begin
          capture  <= '0;
          rb_data  <= cap_next << pad;
          rb_valid <= 1'b1;
        end else begin
          capture <= cap_next;
        end
      end
    end
  end
`else
  logic unused_scan_out;

  assign unused_scan_out = scan_out;
  assign rb_data         = '0;
  assign rb_valid        = 1'b0;
`endif

endmodule

// File: rtl/scan_cfg_ctrl.sv
// Loads the configuration scan chain from a valid/ready word stream, MSB-first.
// Readback of the chain tail is built only when SCAN_CFG_READBACK_EN is defined.
module scan_cfg_ctrl
  import scan_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = SCAN_WORD_W
) (
  input  logic              scan_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              scan_en,
  output logic              scan_in,
  input  logic              scan_out,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int REM_W = cnt_w(CHAIN_LEN);
  localparam int CNT_W = cnt_w(WORD_W);

  scan_state_t      state;
  scan_state_t      state_next;
  logic [REM_W-1:0] remaining;
  logic [CNT_W-1:0] nbits;
  logic             load;
  logic             word_last;

  assign cfg_ready = (state == ST_WAIT_WORD);
  assign load      = cfg_ready && cfg_valid && !abort;

  always_comb begin
    nbits = CNT_W'(WORD_W);
    if (32'(remaining) < WORD_W) nbits = CNT_W'(remaining);
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      ST_IDLE:      if (start) state_next = ST_WAIT_WORD;
      ST_WAIT_WORD: if (cfg_valid) state_next = ST_SHIFT;
      ST_SHIFT: begin
        if (word_last) state_next = (remaining == REM_W'(1)) ? ST_DONE : ST_WAIT_WORD;
      end
      ST_DONE:      state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  // Status outputs are decoded from the next state so they are true flops.
  always_ff @(posedge scan_clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      scan_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state   <= state_next;
      scan_en <= (state_next == ST_SHIFT);
      busy    <= (state_next != ST_IDLE);
      done    <= (state_next == ST_DONE);
      if (state == ST_IDLE) begin
        remaining <= REM_W'(CHAIN_LEN);
      end else if (scan_en) begin
        remaining <= remaining - REM_W'(1);
      end
    end
  end

  scan_word_serializer #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_serializer (
    .scan_clk (scan_clk),
    .rst      (rst),
    .clear    (abort),
    .load     (load),
    .word     (cfg_data),
    .nbits    (nbits),
    .shift    (scan_en),
    .scan_out (scan_out),
    .scan_in  (scan_in),
    .last     (word_last),
    .rb_data  (rb_data),
    .rb_valid (rb_valid)
  );

endmodule

// File: tb/tb_scan_cfg_ctrl.sv
// Bench for scan_cfg_ctrl: a 16-bit and a 12-bit chain driven in lockstep from one host stream.
// Readback expectations follow SCAN_CFG_READBACK_EN.
module tb_scan_cfg_ctrl;

  logic       scan_clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_data = 8'h00;

  logic       cfg_ready_a, scan_en_a, scan_in_a, scan_out_a, busy_a, done_a, rb_valid_a;
  logic [7:0] rb_data_a;
  logic       cfg_ready_b, scan_en_b, scan_in_b, scan_out_b, busy_b, done_b, rb_valid_b;
  logic [7:0] rb_data_b;

  always #5 scan_clk = ~scan_clk;

  scan_cfg_ctrl #(.CHAIN_LEN(16), .WORD_W(8)) dut_a (
    .scan_clk(scan_clk), .rst(rst), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_a),
    .scan_en(scan_en_a), .scan_in(scan_in_a), .scan_out(scan_out_a),
    .busy(busy_a), .done(done_a), .rb_data(rb_data_a), .rb_valid(rb_valid_a)
  );

  scan_cfg_ctrl #(.CHAIN_LEN(12), .WORD_W(8)) dut_b (
    .scan_clk(scan_clk), .rst(rst), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_b),
    .scan_en(scan_en_b), .scan_in(scan_in_b), .scan_out(scan_out_b),
    .busy(busy_b), .done(done_b), .rb_data(rb_data_b), .rb_valid(rb_valid_b)
  );

  // Chain models: bits enter at the head (LSB side) and leave from the MSB tail.
  logic [15:0] chain_a;
  logic [11:0] chain_b;
  logic        preload_en = 1'b1;
  logic [15:0] preload_a = 16'h0000;
  logic [11:0] preload_b = 12'h000;

  assign scan_out_a = chain_a[15];
  assign scan_out_b = chain_b[11];

  always @(posedge scan_clk) begin
    if (preload_en) begin
      chain_a <= preload_a;
      chain_b <= preload_b;
    end else begin
      if (scan_en_a) chain_a <= {chain_a[14:0], scan_in_a};
      if (scan_en_b) chain_b <= {chain_b[10:0], scan_in_b};
    end
  end

  // Event monitors, sampled mid-cycle.
  int cyc = 0;
  int en_a = 0, en_b = 0, dn_a = 0, dn_b = 0, hs_a = 0, hs_b = 0;
  int conflict = 0, rbv_a = 0, rbv_b = 0;
  int start_cyc = 0, done_cyc_a = 0, last_en_cyc_a = 0;
  logic [7:0] rb_q_a[$];
  logic [7:0] rb_q_b[$];

  always @(posedge scan_clk) cyc <= cyc + 1;

  always @(negedge scan_clk) begin
    if (!rst) begin
      if (scan_en_a) begin en_a <= en_a + 1; last_en_cyc_a <= cyc; end
      if (scan_en_b) en_b <= en_b + 1;
      if (done_a) begin dn_a <= dn_a + 1; done_cyc_a <= cyc; end
      if (done_b) dn_b <= dn_b + 1;
      if (cfg_valid && cfg_ready_a) hs_a <= hs_a + 1;
      if (cfg_valid && cfg_ready_b) hs_b <= hs_b + 1;
      if ((scan_en_a && cfg_ready_a) || (scan_en_b && cfg_ready_b)) conflict <= conflict + 1;
      if (start && !busy_a) start_cyc <= cyc;
      if (rb_valid_a) begin rbv_a <= rbv_a + 1; rb_q_a.push_back(rb_data_a); end
      if (rb_valid_b) begin rbv_b <= rbv_b + 1; rb_q_b.push_back(rb_data_b); end
    end
  end

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Host driver: start, then offer two words with optional random valid stalls.
  task automatic run_pass(input logic [7:0] w0, input logic [7:0] w1,
                          input bit stall, input bit extra_start);
    logic [7:0] words[2];
    int idx;
    int guard;
    bit hs;
    words[0] = w0;
    words[1] = w1;
    @(posedge scan_clk); #1 start = 1'b1;
    @(posedge scan_clk); #1 start = 1'b0;
    idx = 0;
    guard = 0;
    while (!(idx == 2 && !busy_a && !busy_b) && guard < 200) begin
      cfg_valid = (idx < 2) && (!stall || $urandom_range(0, 1) == 1);
      cfg_data  = (idx < 2) ? words[idx] : 8'h00;
      start     = extra_start && (guard == 6);
      @(negedge scan_clk);
      hs = cfg_valid && cfg_ready_a;
      @(posedge scan_clk); #1;
      if (hs) idx++;
      guard++;
    end
    cfg_valid = 1'b0;
    start = 1'b0;
    check("pass_within_budget", 32'(guard < 200), 32'd1);
  endtask

  task automatic run_and_check(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                               input logic [15:0] exp_a, input logic [11:0] exp_b,
                               input bit stall, input bit extra_start);
    int b_en_a, b_en_b, b_dn_a, b_dn_b, b_hs_a, b_hs_b, b_conf, b_rbv_a, b_rbv_b, b_qa, b_qb;
    logic [15:0] old_a;
    logic [11:0] old_b;
    b_en_a = en_a; b_en_b = en_b; b_dn_a = dn_a; b_dn_b = dn_b;
    b_hs_a = hs_a; b_hs_b = hs_b; b_conf = conflict;
    b_rbv_a = rbv_a; b_rbv_b = rbv_b; b_qa = rb_q_a.size(); b_qb = rb_q_b.size();
    old_a = chain_a;
    old_b = chain_b;
    run_pass(w0, w1, stall, extra_start);
    @(negedge scan_clk);
    check({tag, "_chain16"}, 32'(chain_a), 32'(exp_a));
    check({tag, "_chain12"}, 32'(chain_b), 32'(exp_b));
    check({tag, "_shifts16"}, en_a - b_en_a, 16);
    check({tag, "_shifts12"}, en_b - b_en_b, 12);
    check({tag, "_done16"}, dn_a - b_dn_a, 1);
    check({tag, "_done12"}, dn_b - b_dn_b, 1);
    check({tag, "_hs16"}, hs_a - b_hs_a, 2);
    check({tag, "_hs12"}, hs_b - b_hs_b, 2);
    check({tag, "_en_in_wait"}, conflict - b_conf, 0);
    if (!stall && !extra_start) begin
      check({tag, "_start_to_done"}, done_cyc_a - start_cyc, 19);
      check({tag, "_done_after_last"}, done_cyc_a - last_en_cyc_a, 1);
    end
`ifdef SCAN_CFG_READBACK_EN
    check({tag, "_rbv16"}, rbv_a - b_rbv_a, 2);
    check({tag, "_rbv12"}, rbv_b - b_rbv_b, 2);
    check({tag, "_rb16_w0"}, 32'(rb_q_a[b_qa]), 32'(old_a[15:8]));
    check({tag, "_rb16_w1"}, 32'(rb_q_a[b_qa+1]), 32'(old_a[7:0]));
    check({tag, "_rb12_w0"}, 32'(rb_q_b[b_qb]), 32'(old_b[11:4]));
    check({tag, "_rb12_w1"}, 32'(rb_q_b[b_qb+1]), 32'({old_b[3:0], 4'h0}));
`else
    check({tag, "_rbv16"}, rbv_a - b_rbv_a, 0);
    check({tag, "_rbv12"}, rbv_b - b_rbv_b, 0);
    check({tag, "_rbdata16"}, 32'(rb_data_a), 32'd0);
`endif
  endtask

  // Wait for the first shift cycle of a freshly started pass.
  task automatic start_and_wait_shift(input logic [7:0] w);
    int g;
    @(posedge scan_clk); #1 start = 1'b1;
    @(posedge scan_clk); #1 start = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = w;
    g = 0;
    @(negedge scan_clk);
    while (!scan_en_a && g < 20) begin
      @(negedge scan_clk);
      g++;
    end
    check("shift_seen_within_budget", 32'(scan_en_a), 32'd1);
  endtask

  typedef struct {
    logic [7:0]  w0;
    logic [7:0]  w1;
    logic [15:0] exp_a;
    logic [11:0] exp_b;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int b_dn_a, b_en_a, b_rbv_a;
    logic [7:0] w0, w1;

    vecs[0] = '{8'hA5, 8'h3C, 16'hA53C, 12'hA53};
    vecs[1] = '{8'hF0, 8'hBF, 16'hF0BF, 12'hF0B};
    vecs[2] = '{8'h00, 8'hFF, 16'h00FF, 12'h00F};
    vecs[3] = '{8'h81, 8'h7E, 16'h817E, 12'h817};

    #1 rst = 1'b1;
    #20;
    check("rst_scan_en", 32'(scan_en_a), 32'd0);
    check("rst_scan_in", 32'(scan_in_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready_a), 32'd0);
    check("rst_rb_valid", 32'(rb_valid_a), 32'd0);
    check("rst_rb_data", 32'(rb_data_a), 32'd0);
    check("rst_busy12", 32'(busy_b), 32'd0);
    @(negedge scan_clk);
    rst = 1'b0;
    preload_en = 1'b0;

    for (int i = 0; i < 4; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].w0, vecs[i].w1,
                    vecs[i].exp_a, vecs[i].exp_b, 1'b0, 1'b0);

    // Random words, random valid stalls, spurious start while busy on the first one.
    for (int i = 0; i < 6; i++) begin
      w0 = 8'($urandom);
      w1 = 8'($urandom);
      run_and_check($sformatf("rnd%0d", i), w0, w1, {w0, w1}, 12'({w0, w1} >> 4),
                    1'b1, i == 0);
    end

    // start and abort together in IDLE: abort wins.
    @(negedge scan_clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge scan_clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle_busy", 32'(busy_a), 32'd0);
    check("start_abort_idle_ready", 32'(cfg_ready_a), 32'd0);

    // Abort during the 5th shift cycle.
    b_dn_a = dn_a;
    b_en_a = en_a;
    b_rbv_a = rbv_a;
    start_and_wait_shift(8'hC3);
    repeat (4) @(negedge scan_clk);
    abort = 1'b1;
    @(posedge scan_clk); #1 abort = 1'b0;
    cfg_valid = 1'b0;
    @(negedge scan_clk);
    check("abort_scan_en_low", 32'(scan_en_a), 32'd0);
    check("abort_busy_low", 32'(busy_a), 32'd0);
    check("abort_scan_en_low12", 32'(scan_en_b), 32'd0);
    repeat (10) @(negedge scan_clk);
    check("abort_no_done", dn_a - b_dn_a, 0);
    check("abort_shift_count", en_a - b_en_a, 5);
    check("abort_no_rb_valid", rbv_a - b_rbv_a, 0);
    run_and_check("after_abort", 8'h5A, 8'hC3, 16'h5AC3, 12'h5AC, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a shift.
    start_and_wait_shift(8'hFF);
    #2 rst = 1'b1;
    #1;
    check("async_rst_scan_en", 32'(scan_en_a), 32'd0);
    check("async_rst_scan_in", 32'(scan_in_a), 32'd0);
    check("async_rst_busy", 32'(busy_a), 32'd0);
    check("async_rst_ready", 32'(cfg_ready_a), 32'd0);
    cfg_valid = 1'b0;
    @(negedge scan_clk);
    rst = 1'b0;

    // Readback: chains preloaded with known contents before an A5/3C pass.
    @(negedge scan_clk);
    preload_a = 16'h1234;
    preload_b = 12'h123;
    preload_en = 1'b1;
    @(negedge scan_clk);
    preload_en = 1'b0;
    run_and_check("readback", 8'hA5, 8'h3C, 16'hA53C, 12'hA53, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/scan_cfg_ctrl.md
# scan_cfg_ctrl

Sequencer that loads the FPGA configuration scan chain from a word-wide host stream. It accepts configuration words over a valid/ready handshake and serialises each word MSB-first onto `scan_in`. It drives `scan_en` for exactly `CHAIN_LEN` shift cycles, then reports completion. It sits between the host/bitstream loader and the head of the configuration chain, and runs in the `scan_clk` domain.

## Interface
Parameters:
- `CHAIN_LEN`, default 16: total number of bits in the scan chain; must be ≥ 1.
- `WORD_W`, default 8: host word width; must be ≥ 2.

Ports:
- `scan_clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: reset; **asynchronous, active-high**.
- `start`, input, 1: one-cycle request to begin a configuration pass; sampled only in IDLE.
- `abort`, input, 1: cancels the pass in progress.
- `cfg_data`, input, `WORD_W`: configuration word.
- `cfg_valid`, input, 1: `cfg_data` is valid.
- `cfg_ready`, output, 1: controller accepts a word this cycle.
- `scan_en`, output, 1: chain shift enable (registered).
- `scan_in`, output, 1: serial bit to the chain head (registered).
- `scan_out`, input, 1: chain tail, used only for readback.
- `busy`, output, 1: high from the cycle after `start` is accepted until the pass ends.
- `done`, output, 1: one-cycle pulse after the final bit has shifted.
- `rb_data`, output, `WORD_W`: readback word.
- `rb_valid`, output, 1: one-cycle pulse qualifying `rb_data`.

## Operation
- Reset values: all outputs are 0, the state is IDLE, and the counters are 0.
- **IDLE**
  - `start`=1 → WAIT_WORD.
  - `remaining` is loaded with `CHAIN_LEN`.
- **WAIT_WORD**
  - `cfg_ready`=1 in this state only; `scan_en`=0.
  - A transfer occurs when `cfg_valid` and `cfg_ready` are both high.
  - On a transfer, the word is latched into the serialiser buffer and `nbits` = min(`WORD_W`, `remaining`) → SHIFT.
- **SHIFT**
  - `scan_en`=1 and `scan_in` = the buffer MSB; the buffer shifts left each cycle.
  - The state lasts exactly `nbits` cycles, during which `remaining` decrements once per cycle.
  - When the word completes: `remaining`=0 → DONE, otherwise → WAIT_WORD.
- **DONE**
  - `done`=1 for one cycle → IDLE.
- Partial final word: when `CHAIN_LEN mod WORD_W` = r ≠ 0, only the r MSBs of the last word are shifted; its low bits are discarded.
- Word count per pass: ceil(`CHAIN_LEN`/`WORD_W`).
- Counter width: `remaining` is $clog2(`CHAIN_LEN`+1) bits; the per-word counter is $clog2(`WORD_W`+1) bits. Neither counter wraps.
- `abort` has priority over every transition:
  - Any state → IDLE on the next edge, with `scan_en` low the cycle after.
  - No `done` pulse is produced, and the chain contents are undefined.
- `start` while `busy` is ignored.
- `start` and `abort` high together in IDLE: `abort` wins and the controller stays in IDLE.
- Asserting `rst` mid-pass forces reset values immediately, without waiting for a clock edge.

## Timing
- The word is accepted on edge k. `scan_en`/`scan_in` are high/valid in cycles k+1 … k+`nbits`, and the chain captures on edges k+1 … k+`nbits`.
- There is a one-cycle gap with `scan_en`=0 per word (WAIT_WORD), even when `cfg_valid` is held high. The chain holds its state during the gap.
- Full 16-bit pass with `WORD_W`=8 and `cfg_valid` always high:
  - `start` on edge 0; 19 `scan_en`-low/high cycles in total.
  - `done` is high in the cycle after the last shift.
- `busy` stays high through the DONE cycle and falls when the controller returns to IDLE.

## Configuration
- Macro `SCAN_CFG_READBACK_EN`.
- **Defined:**
  - On every edge where `scan_en`=1, `scan_out` (the old chain bit) is sampled and shifted MSB-first into a capture register.
  - `rb_data`/`rb_valid` are registered together and update in the cycle after each word's last shift.
  - A partial final word is left-justified in `rb_data`, with its low bits 0.
  - `abort` clears the capture register and suppresses `rb_valid`.
- **Undefined:** `rb_data` and `rb_valid` are tied to 0. The ports remain present.

## Structure
- Shared package `scan_cfg_pkg`:
  - state enum (IDLE, WAIT_WORD, SHIFT, DONE)
  - `SCAN_WORD_W` default constant
  - counter-width helper
- One sub-module, `scan_word_serializer`:
  - load / shift-left buffer with MSB output
  - per-word bit counter
  - optional capture register for readback
- The top level holds the FSM, `remaining`, and the handshake.

## Test plan
- `CHAIN_LEN`=16, `WORD_W`=8, words 0xA5 then 0x3C behind a 16-bit chain model:
  - chain = 0xA53C;
  - `done` pulses once;
  - 16 `scan_en` cycles in total.
- `CHAIN_LEN`=12, words 0xF0 then 0xBF:
  - only 1011 of the second word is shifted;
  - chain = 0xF0B;
  - exactly 2 handshakes.
- `cfg_valid` toggling 1-0-1 with random stalls:
  - `scan_en` is never high in WAIT_WORD;
  - the final chain contents are identical to the no-stall run.
- `abort` at the 5th shift cycle, then a fresh `start`:
  - no `done` for the aborted pass;
  - `scan_en` is low the next cycle;
  - the second pass completes correctly.
- `rst` asserted mid-SHIFT: all outputs drop to 0 asynchronously; `start` during `busy` has no effect.
- Readback with `SCAN_CFG_READBACK_EN` defined, chain preloaded with 0x1234 and a 0xA53C pass:
  - `rb_data` = 0x12 then 0x34;
  - `rb_valid` is high for one cycle each time.
